// File: rtl/arith_pkg.sv
// Shared opcode and FSM-state definitions for the multi-cycle arithmetic unit.
package arith_pkg;

  localparam logic [1:0] FUNC_ADD = 2'b00;
  localparam logic [1:0] FUNC_SUB = 2'b01;
  localparam logic [1:0] FUNC_MUL = 2'b10;
  localparam logic [1:0] FUNC_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_DIV_BUSY = 2'b01,
    ST_DONE     = 2'b10
  } state_e;

endpackage

// File: rtl/arith_unit_mc_seq_divider.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first.
// done/quotient/remainder present the final step's values during the last busy cycle.
module seq_divider #(
  parameter int IN_WIDTH = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic [IN_WIDTH-1:0] dividend,
  input  logic [IN_WIDTH-1:0] divisor,
  output logic                done,
  output logic [IN_WIDTH-1:0] quotient,
  output logic [IN_WIDTH-1:0] remainder
);

  localparam int CNT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;

  logic                busy_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [IN_WIDTH-1:0] rem_r;
  logic [IN_WIDTH-1:0] quo_r;
  logic [IN_WIDTH-1:0] dvs_r;
  logic [IN_WIDTH:0]   trial_s;
  logic [IN_WIDTH:0]   diff_s;
  logic [IN_WIDTH-1:0] rem_nx_s;
  logic [IN_WIDTH-1:0] quo_nx_s;
  logic                qbit_s;

  // Shift-subtract step; the borrow of the trial subtraction decides the quotient bit.
  always_comb begin
    trial_s = {rem_r, quo_r[IN_WIDTH-1]};
    diff_s  = trial_s - {1'b0, dvs_r};
    qbit_s  = ~diff_s[IN_WIDTH];
    if (qbit_s) begin
      rem_nx_s = diff_s[IN_WIDTH-1:0];
    end else begin
      rem_nx_s = trial_s[IN_WIDTH-1:0];
    end
    quo_nx_s = {quo_r[IN_WIDTH-2:0], qbit_s};
  end

  // Operand capture, iteration state and bit counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      busy_r <= 1'b0;
      cnt_r  <= '0;
      rem_r  <= '0;
      quo_r  <= '0;
      dvs_r  <= '0;
    end else if (start) begin
      busy_r <= 1'b1;
      cnt_r  <= CNT_W'(IN_WIDTH - 1);
      rem_r  <= '0;
      quo_r  <= dividend;
      dvs_r  <= divisor;
    end else if (busy_r) begin
      rem_r <= rem_nx_s;
      quo_r <= quo_nx_s;
      if (cnt_r == '0) begin
        busy_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r - CNT_W'(1);
      end
    end
  end

  assign done      = busy_r && (cnt_r == '0);
  assign quotient  = quo_nx_s;
  assign remainder = rem_nx_s;

endmodule

// File: rtl/arith_unit_mc.sv
// Handshaked multi-cycle ADD/SUB/MUL/DIV unit with held results under backpressure.
// Define ARITH_UNIT_DIV_EN to build the iterative divider; otherwise DIV reports an error.
module arith_unit_mc
  import arith_pkg::*;
#(
  parameter  int IN_WIDTH  = 16,
  localparam int OUT_WIDTH = 2 * IN_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [IN_WIDTH-1:0]  A,
  input  logic [IN_WIDTH-1:0]  B,
  input  logic [1:0]           ALU_FUNC,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  output logic [OUT_WIDTH-1:0] Arith_OUT,
  output logic                 Carry_OUT,
  output logic                 Arith_Err,
  output logic                 Arith_Flag,
  input  logic                 OUT_READY
);

  state_e                state_r, state_s;
  logic [OUT_WIDTH-1:0]  out_r, out_s;
  logic                  carry_r, carry_s;
  logic                  err_r, err_s;
  logic                  flag_r;
  logic                  in_ready_s;
  logic                  accept_s;
  logic [IN_WIDTH:0]     sum_s;
  logic [IN_WIDTH:0]     diff_s;
  logic [OUT_WIDTH-1:0]  prod_s;
  logic [OUT_WIDTH-1:0]  op_out_s;
  logic                  op_carry_s;
  logic                  op_err_s;
  logic                  op_iter_s;
  logic                  div_done_s;
  logic [IN_WIDTH-1:0]   quo_s;
  logic [IN_WIDTH-1:0]   rem_s;

  assign in_ready_s = RST && ((state_r == ST_IDLE) || ((state_r == ST_DONE) && OUT_READY));
  assign accept_s   = IN_VALID && in_ready_s;

  assign sum_s  = {1'b0, A} + {1'b0, B};
  assign diff_s = {1'b0, A} - {1'b0, B};
  assign prod_s = {{IN_WIDTH{1'b0}}, A} * {{IN_WIDTH{1'b0}}, B};

`ifdef ARITH_UNIT_DIV_EN
  logic div_start_s;

  assign div_start_s = accept_s && op_iter_s;

  seq_divider #(
    .IN_WIDTH (IN_WIDTH)
  ) u_div (
    .CLK       (CLK),
    .RST       (RST),
    .start     (div_start_s),
    .dividend  (A),
    .divisor   (B),
    .done      (div_done_s),
    .quotient  (quo_s),
    .remainder (rem_s)
  );
`else
  assign div_done_s = 1'b0;
  assign quo_s      = {IN_WIDTH{1'b0}};
  assign rem_s      = {IN_WIDTH{1'b0}};
`endif

  // Single-cycle result of the request on the inputs; op_iter_s marks a divider launch.
  always_comb begin
    op_out_s   = {OUT_WIDTH{1'b0}};
    op_carry_s = 1'b0;
    op_err_s   = 1'b0;
    op_iter_s  = 1'b0;
    case (ALU_FUNC)
      FUNC_ADD: begin
        op_out_s   = {{IN_WIDTH{1'b0}}, sum_s[IN_WIDTH-1:0]};
        op_carry_s = sum_s[IN_WIDTH];
      end
      FUNC_SUB: begin
        op_out_s   = {{IN_WIDTH{1'b0}}, diff_s[IN_WIDTH-1:0]};
        op_carry_s = diff_s[IN_WIDTH];
      end
      FUNC_MUL: begin
        op_out_s = prod_s;
      end
      FUNC_DIV: begin
`ifdef ARITH_UNIT_DIV_EN
        if (B == {IN_WIDTH{1'b0}}) begin
          op_out_s = {A, {IN_WIDTH{1'b1}}};
          op_err_s = 1'b1;
        end else begin
          op_iter_s = 1'b1;
        end
`else
        op_err_s = 1'b1;
`endif
      end
      default: begin
        op_err_s = 1'b1;
      end
    endcase
  end

  // Next state and next result; an accept is only possible from IDLE or a consumed DONE.
  always_comb begin
    state_s = state_r;
    out_s   = out_r;
    carry_s = carry_r;
    err_s   = err_r;
    if (accept_s) begin
      if (op_iter_s) begin
        state_s = ST_DIV_BUSY;
      end else begin
        state_s = ST_DONE;
        out_s   = op_out_s;
        carry_s = op_carry_s;
        err_s   = op_err_s;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_IDLE;
        end
        ST_DIV_BUSY: begin
          if (div_done_s) begin
            state_s = ST_DONE;
            out_s   = {rem_s, quo_s};
            carry_s = 1'b0;
            err_s   = 1'b0;
          end else begin
            state_s = ST_DIV_BUSY;
          end
        end
        ST_DONE: begin
          if (OUT_READY) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_DONE;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= ST_IDLE;
      out_r   <= {OUT_WIDTH{1'b0}};
      carry_r <= 1'b0;
      err_r   <= 1'b0;
      flag_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      out_r   <= out_s;
      carry_r <= carry_s;
      err_r   <= err_s;
      flag_r  <= (state_s == ST_DONE);
    end
  end

  assign IN_READY   = in_ready_s;
  assign Arith_OUT  = out_r;
  assign Carry_OUT  = carry_r;
  assign Arith_Err  = err_r;
  assign Arith_Flag = flag_r;

endmodule

// File: doc/arith_unit_mc.md
# arith_unit_mc

Multi-cycle, handshaked successor to the single-cycle arithmetic unit in the ALU datapath. It performs ADD, SUB, MUL and DIV on IN_WIDTH-bit unsigned operands and returns a full-width result: double-width product, and remainder plus quotient for DIV. Requests are accepted through a valid/ready handshake. ADD, SUB and MUL complete in one cycle; DIV runs on an iterative restoring divider. The result is held under backpressure until the ALU top or a downstream consumer takes it.

## Interface
- IN_WIDTH, 16, operand width; legal range 4..32.
- OUT_WIDTH, 2*IN_WIDTH, result width; fixed relation, not overridable.
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- A  in  IN_WIDTH  operand A, sampled on accept.
- B  in  IN_WIDTH  operand B, sampled on accept.
- ALU_FUNC  in  2  opcode: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
- IN_VALID  in  1  request valid.
- IN_READY  out  1  unit can accept a request.
- Arith_OUT  out  OUT_WIDTH  result.
- Carry_OUT  out  1  carry on ADD, borrow on SUB, 0 otherwise.
- Arith_Err  out  1  DIV by zero, or DIV issued while the divider is compiled out.
- Arith_Flag  out  1  result valid.
- OUT_READY  in  1  consumer takes the result.

## Operation
- Accept occurs when IN_VALID && IN_READY. A, B and ALU_FUNC are captured at accept; later changes on those inputs have no effect.
- ADD: Arith_OUT = {0, (A+B) mod 2^IN_WIDTH}; Carry_OUT = bit IN_WIDTH of the sum.
- SUB: Arith_OUT = {0, (A-B) mod 2^IN_WIDTH}; Carry_OUT = 1 iff A < B.
- MUL: Arith_OUT = full 2*IN_WIDTH unsigned product; Carry_OUT = 0.
- DIV: Arith_OUT = {remainder, quotient}; Carry_OUT = 0.
- DIV with B == 0: quotient all ones, remainder = A, Arith_Err = 1. No iteration is performed.
- Arith_Err = 0 for every other completed operation.
- State machine, reset state IDLE:
  - IDLE: IN_READY = 1. Accept of ADD, SUB, MUL or div-by-zero -> DONE. Accept of DIV with B != 0 -> DIV_BUSY.
  - DIV_BUSY: IN_READY = 0. One quotient bit per cycle, MSB first. A down-counter loaded with IN_WIDTH-1 moves the state to DONE after its 0 step.
  - DONE: Arith_Flag = 1 and all outputs are held stable. If OUT_READY = 1: with a new accept in the same cycle, take that request's path; otherwise -> IDLE.
- IN_READY = (state == IDLE) || (state == DONE && OUT_READY). This allows one request per cycle for non-DIV ops.
- RST asserted, including mid-DIV: immediately return to IDLE and clear the counter and partial remainder. The in-flight result is discarded and nothing is reported.
- Reset values: IN_READY 0 while RST is low and 1 after release; Arith_OUT 0, Carry_OUT 0, Arith_Err 0, Arith_Flag 0.

## Timing
- ADD, SUB, MUL and div-by-zero: Arith_Flag rises on the edge after accept (latency 1).
- DIV with B != 0: Arith_Flag rises IN_WIDTH+1 edges after accept (17 for the default width).
- Arith_Flag stays high until the first cycle with OUT_READY = 1. It drops on the following edge unless a new accept completes in one cycle.
- With OUT_READY tied high and a continuous stream of non-DIV requests, throughput is one result per cycle.

## Configuration
- ARITH_UNIT_DIV_EN defined: the iterative divider is instantiated and DIV behaves as described under Operation.
- ARITH_UNIT_DIV_EN undefined: the divider logic is removed. DIV completes in 1 cycle with Arith_OUT = 0, Carry_OUT = 0 and Arith_Err = 1. DIV_BUSY is unreachable.

## Structure
- Package arith_pkg holds:
  - opcode localparams: FUNC_ADD, FUNC_SUB, FUNC_MUL, FUNC_DIV.
  - FSM state encoding: ST_IDLE, ST_DIV_BUSY, ST_DONE.
- Sub-module seq_divider, parameterised by IN_WIDTH:
  - inputs: start, dividend, divisor.
  - outputs: done, quotient, remainder.
  - contains the shift/subtract datapath and the bit counter.
- The top module owns the FSM, the operand and result registers, and the single-cycle ADD, SUB and MUL logic.

## Test plan
All values use IN_WIDTH = 16.
- ADD, A=0xFFFF, B=0x0001, OUT_READY=1 -> next cycle Arith_OUT=0x0000_0000, Carry_OUT=1, Arith_Flag=1 for 1 cycle.
- SUB, A=3, B=5 -> Arith_OUT=0x0000_FFFE, Carry_OUT=1. MUL, A=0xFFFF, B=0xFFFF -> Arith_OUT=0xFFFE_0001, Carry_OUT=0.
- DIV, A=100, B=7 -> IN_READY low for 16 cycles, then Arith_OUT=0x0002_000E and Arith_Err=0, 17 edges after accept.
- DIV, A=0x1234, B=0 -> Arith_OUT=0x1234_FFFF and Arith_Err=1 after 1 cycle. The same stimulus with ARITH_UNIT_DIV_EN undefined -> Arith_OUT=0, Arith_Err=1.
- Backpressure: OUT_READY=0 for 5 cycles after an ADD result -> outputs held and IN_READY=0. Then OUT_READY=1 together with IN_VALID for a MUL -> MUL result on the next edge.
- RST pulsed low 8 cycles into a DIV -> all outputs 0 immediately. After release, IN_READY=1 and no stale result appears.
